bus_master_ctrl: RTL and testbench
==================================

// Module: bus_master_ctrl
// PURPOSE
//  Master-side bus sequencer placed between a CPU memory stage and one port of the shared bus.
//  It turns a single-cycle CPU access request into the full bus transaction:
//  - arbitration: bus_req_/bus_grnt_
//  - address phase: bus_as_, bus_addr, bus_rw, bus_wr_data
//  - wait for slave ready: bus_rdy_
//  It returns read data, done and error status to the CPU, with optional bus hold for back-to-back access.
// PARAMETERS
//  TIMEOUT_CYCLES  16  ACCESS cycles allowed without bus_rdy_ before abort; 0 = never time out
//  HOLD_CYCLES      0  idle cycles the grant is kept after completion; 0 = release immediately
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset        in   1   asynchronous, active-high reset
//  cpu_req      in   1   access request; accepted when cpu_busy==0
//  cpu_rw       in   1   1 = read, 0 = write (same encoding as bus_rw)
//  cpu_addr     in   30  word address
//  cpu_wr_data  in   32  write data
//  cpu_rd_data  out  32  read data of last completed read
//  cpu_busy     out  1   transaction in flight (REQ or ACCESS)
//  cpu_done     out  1   one-cycle pulse: transaction finished (ok or error)
//  cpu_err      out  1   one-cycle pulse with cpu_done: timeout or grant lost
//  bus_req_     out  1   bus request to arbiter, active low
//  bus_grnt_    in   1   grant from arbiter, active low
//  bus_addr     out  30  bus address
//  bus_as_      out  1   address strobe, active low
//  bus_rw       out  1   1 = read, 0 = write
//  bus_wr_data  out  32  bus write data
//  bus_rd_data  in   32  read data from slave mux
//  bus_rdy_     in   1   slave ready from slave mux, active low
// BEHAVIOUR
//  Outputs and timing
//  - All outputs are registered.
//  - Reset values: bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0,
//    cpu_rd_data=0, cpu_busy=0, cpu_done=0, cpu_err=0, state=IDLE, counter=0.
//  - Reset asserted mid-transaction drops bus_as_/bus_req_ to 1 immediately; nothing is completed.
//  States (one-hot or binary, encodings in bus.h)
//  - IDLE: bus_req_=1.
//    - cpu_req=1 -> latch rw/addr/wr_data; next cycle REQ with bus_req_=0 and cpu_busy=1.
//  - REQ: hold bus_req_=0 until bus_grnt_ is sampled 0.
//    - next cycle ACCESS: bus_as_=0; bus_addr/bus_rw/bus_wr_data = latched values.
//  - ACCESS: bus_as_=0; counter increments each cycle.
//    - bus_rdy_ sampled 0 -> next cycle bus_as_=1 and cpu_done=1.
//      Reads also load cpu_rd_data from bus_rd_data; writes leave it unchanged.
//      Then go to HOLD if HOLD_CYCLES>0, else IDLE with bus_req_=1.
//    - counter reaches TIMEOUT_CYCLES (when nonzero) -> abort: bus_as_=1, bus_req_=1,
//      cpu_done=1, cpu_err=1, cpu_rd_data unchanged; go to IDLE.
//    - bus_grnt_ sampled 1 -> same abort as timeout.
//    - bus_rdy_=0 and timeout in the same cycle -> rdy_ wins, normal completion.
//  - HOLD: bus_req_=0, bus_as_=1, cpu_busy=0; counter counts idle cycles.
//    - cpu_req=1 -> latch; next cycle ACCESS directly, skipping arbitration.
//    - HOLD_CYCLES reached or bus_grnt_=1 -> IDLE, bus_req_=1.
//  Handshake rules
//  - Minimum latency from cpu_req to cpu_done is 3 cycles with a same-cycle grant and zero-wait rdy_.
//  - cpu_req while cpu_busy=1 is ignored; nothing is queued.
//  - The counter clears on every state entry. Its width is clog2(max(TIMEOUT_CYCLES,HOLD_CYCLES)+1).
// STRUCTURE
//  - bus.h holds shared constants:
//    `ENABLE_/`DISABLE_, `READ/`WRITE, WORD_ADDR_W=30, WORD_DATA_W=32,
//    and the state encodings `BMC_IDLE/`BMC_REQ/`BMC_ACCESS/`BMC_HOLD.
//  - One sub-module: bus_ctrl_timer, a clearable up-counter with compare-equal output,
//    shared by the timeout and hold functions.
// TESTING (bench: bus_arbiter + bus_master_mux + bus_addr_dec + bus_slave_mux + regfile as slave 0)
//  1. Write: cpu_req, rw=0, addr=0, data=22, grant same cycle
//     -> bus_as_ low 1 cycle, cpu_done at T+3, cpu_err=0, regfile[0]=22.
//  2. Read: addr=0 after test 1 -> cpu_rd_data=22, cpu_done pulse, bus_req_ back to 1 the next cycle.
//  3. Grant delayed: another master holds the bus 5 cycles
//     -> stay in REQ with bus_as_=1 throughout; ACCESS only after bus_grnt_=0.
//  4. Timeout: slave never asserts rdy_, TIMEOUT_CYCLES=4
//     -> cpu_done & cpu_err at ACCESS+4, bus_req_=1, cpu_rd_data unchanged.
//  5. HOLD_CYCLES=2: second cpu_req 1 cycle after done
//     -> bus_req_ stays 0 and ACCESS starts without re-arbitration;
//     with no second request, bus_req_ returns to 1 after 2 cycles.
//  6. Reset pulse during ACCESS -> bus_as_=1, bus_req_=1, cpu_busy=0 at once; no cpu_done pulse.

Source files
------------

// File: rtl/bus_master_ctrl_pkg.sv
// Shared constants and state encoding for the bus master sequencer.
// Bus control strobes are active low.
package bus_master_ctrl_pkg;

    localparam int unsigned WordAddrW = 30;
    localparam int unsigned WordDataW = 32;

    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;
    localparam logic Read     = 1'b1;
    localparam logic Write    = 1'b0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StAccess = 2'd2,
        StHold   = 2'd3
    } bmc_state_e;

endpackage

// File: rtl/bus_ctrl_timer.sv
// Clearable free-running up-counter with an equality flag against a limit.
// Shared by the access-timeout and the grant-hold functions.
module bus_ctrl_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [Width-1:0] limit,
    output logic             hit
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign hit = (count_q == limit);

endmodule

// File: rtl/bus_master_ctrl.sv
// Master-side bus sequencer: turns a single-cycle CPU request into an arbitrated
// bus transaction and returns read data and done/error status.
module bus_master_ctrl
    import bus_master_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_rw,
    input  logic [WordAddrW-1:0] cpu_addr,
    input  logic [WordDataW-1:0] cpu_wr_data,
    output logic [WordDataW-1:0] cpu_rd_data,
    output logic                 cpu_busy,
    output logic                 cpu_done,
    output logic                 cpu_err,
    output logic                 bus_req_,
    input  logic                 bus_grnt_,
    output logic [WordAddrW-1:0] bus_addr,
    output logic                 bus_as_,
    output logic                 bus_rw,
    output logic [WordDataW-1:0] bus_wr_data,
    input  logic [WordDataW-1:0] bus_rd_data,
    input  logic                 bus_rdy_
);

    localparam int unsigned MaxCycles = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES
                                                                       : HOLD_CYCLES;
    localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles + 1) : 1;
    // Counter starts at 0 on entry, so the last allowed cycle sees count == N-1.
    localparam logic [CntW-1:0] TimeoutLimit =
        (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CntW-1:0] HoldLimit =
        (HOLD_CYCLES > 0) ? CntW'(HOLD_CYCLES - 1) : '0;

    bmc_state_e           state_q;
    logic                 req_rw_q;
    logic [WordAddrW-1:0] req_addr_q;
    logic [WordDataW-1:0] req_wr_data_q;

    logic            timer_clr;
    logic            timer_hit;
    logic [CntW-1:0] timer_limit;
    logic            timeout_hit;
    logic            hold_leave;

    always_comb begin
        timeout_hit = timer_hit && (TIMEOUT_CYCLES != 0);
        hold_leave  = (state_q == StHold) && (cpu_req || bus_grnt_ || timer_hit);
        timer_limit = (state_q == StHold) ? HoldLimit : TimeoutLimit;
        // Held at zero outside ACCESS/HOLD and on every exit, so each entry starts from 0.
        timer_clr   = (state_q == StIdle) || (state_q == StReq) || hold_leave ||
                      ((state_q == StAccess) && (!bus_rdy_ || timeout_hit || bus_grnt_));
    end

    bus_ctrl_timer #(
        .Width(CntW)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (timer_clr),
        .limit(timer_limit),
        .hit  (timer_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            req_rw_q      <= Read;
            req_addr_q    <= '0;
            req_wr_data_q <= '0;
            cpu_rd_data   <= '0;
            cpu_busy      <= 1'b0;
            cpu_done      <= 1'b0;
            cpu_err       <= 1'b0;
            bus_req_      <= Disable_;
            bus_as_       <= Disable_;
            bus_rw        <= Read;
            bus_addr      <= '0;
            bus_wr_data   <= '0;
        end else begin
            cpu_done <= 1'b0;
            cpu_err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cpu_req) begin
                        req_rw_q      <= cpu_rw;
                        req_addr_q    <= cpu_addr;
                        req_wr_data_q <= cpu_wr_data;
                        bus_req_      <= Enable_;
                        cpu_busy      <= 1'b1;
                        state_q       <= StReq;
                    end
                end
                StReq: begin
                    if (bus_grnt_ == Enable_) begin
                        bus_as_     <= Enable_;
                        bus_rw      <= req_rw_q;
                        bus_addr    <= req_addr_q;
                        bus_wr_data <= req_wr_data_q;
                        state_q     <= StAccess;
                    end
                end
                StAccess: begin
                    // A completed transfer wins over a coincident timeout or grant loss.
                    if (bus_rdy_ == Enable_) begin
                        bus_as_  <= Disable_;
                        cpu_done <= 1'b1;
                        cpu_busy <= 1'b0;
                        if (bus_rw == Read) begin
                            cpu_rd_data <= bus_rd_data;
                        end
                        if (HOLD_CYCLES > 0) begin
                            state_q <= StHold;
                        end else begin
                            bus_req_ <= Disable_;
                            state_q  <= StIdle;
                        end
                    end else if (timeout_hit || (bus_grnt_ == Disable_)) begin
                        bus_as_  <= Disable_;
                        bus_req_ <= Disable_;
                        cpu_done <= 1'b1;
                        cpu_err  <= 1'b1;
                        cpu_busy <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                StHold: begin
                    if (bus_grnt_ == Disable_) begin
                        // Grant taken away: a new request must re-arbitrate.
                        if (cpu_req) begin
                            req_rw_q      <= cpu_rw;
                            req_addr_q    <= cpu_addr;
                            req_wr_data_q <= cpu_wr_data;
                            cpu_busy      <= 1'b1;
                            state_q       <= StReq;
                        end else begin
                            bus_req_ <= Disable_;
                            state_q  <= StIdle;
                        end
                    end else if (cpu_req) begin
                        bus_as_     <= Enable_;
                        bus_rw      <= cpu_rw;
                        bus_addr    <= cpu_addr;
                        bus_wr_data <= cpu_wr_data;
                        cpu_busy    <= 1'b1;
                        state_q     <= StAccess;
                    end else if (timer_hit) begin
                        bus_req_ <= Disable_;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench: instance A (timeout 4, no hold) and instance B (timeout 4, hold 2),
// each with a small arbiter/slave model built from bench logic.
module tb_bus_master_ctrl;
    import bus_master_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A signals and environment
    logic        a_cpu_req = 1'b0, a_cpu_rw = 1'b1;
    logic [29:0] a_cpu_addr = '0;
    logic [31:0] a_cpu_wr_data = '0, a_cpu_rd_data, a_bus_wr_data, a_bus_rd_data;
    logic        a_cpu_busy, a_cpu_done, a_cpu_err, a_bus_req_, a_bus_grnt_;
    logic [29:0] a_bus_addr;
    logic        a_bus_as_, a_bus_rw, a_bus_rdy_;
    logic        a_other_owns = 1'b0, a_stall = 1'b0;
    logic [31:0] a_mem [16];

    assign a_bus_grnt_   = a_bus_req_ | a_other_owns;
    assign a_bus_rdy_    = a_bus_as_ | a_stall;
    assign a_bus_rd_data = a_mem[a_bus_addr[3:0]];
    always @(posedge clk) begin
        if (!a_bus_rdy_ && a_bus_rw == Write) a_mem[a_bus_addr[3:0]] <= a_bus_wr_data;
    end

    // Instance B signals: always granted, zero-wait slave returning an address pattern
    logic        b_cpu_req = 1'b0, b_cpu_rw = 1'b1;
    logic [29:0] b_cpu_addr = '0;
    logic [31:0] b_cpu_wr_data = '0, b_cpu_rd_data, b_bus_wr_data, b_bus_rd_data;
    logic        b_cpu_busy, b_cpu_done, b_cpu_err, b_bus_req_, b_bus_grnt_;
    logic [29:0] b_bus_addr;
    logic        b_bus_as_, b_bus_rw, b_bus_rdy_;

    assign b_bus_grnt_   = b_bus_req_;
    assign b_bus_rdy_    = b_bus_as_;
    assign b_bus_rd_data = {2'b00, b_bus_addr} ^ 32'h5A5A_0000;

    bus_master_ctrl #(.TIMEOUT_CYCLES(4), .HOLD_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset), .cpu_req(a_cpu_req), .cpu_rw(a_cpu_rw),
        .cpu_addr(a_cpu_addr), .cpu_wr_data(a_cpu_wr_data), .cpu_rd_data(a_cpu_rd_data),
        .cpu_busy(a_cpu_busy), .cpu_done(a_cpu_done), .cpu_err(a_cpu_err),
        .bus_req_(a_bus_req_), .bus_grnt_(a_bus_grnt_), .bus_addr(a_bus_addr),
        .bus_as_(a_bus_as_), .bus_rw(a_bus_rw), .bus_wr_data(a_bus_wr_data),
        .bus_rd_data(a_bus_rd_data), .bus_rdy_(a_bus_rdy_)
    );

    bus_master_ctrl #(.TIMEOUT_CYCLES(4), .HOLD_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .cpu_req(b_cpu_req), .cpu_rw(b_cpu_rw),
        .cpu_addr(b_cpu_addr), .cpu_wr_data(b_cpu_wr_data), .cpu_rd_data(b_cpu_rd_data),
        .cpu_busy(b_cpu_busy), .cpu_done(b_cpu_done), .cpu_err(b_cpu_err),
        .bus_req_(b_bus_req_), .bus_grnt_(b_bus_grnt_), .bus_addr(b_bus_addr),
        .bus_as_(b_bus_as_), .bus_rw(b_bus_rw), .bus_wr_data(b_bus_wr_data),
        .bus_rd_data(b_bus_rd_data), .bus_rdy_(b_bus_rdy_)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_issue(input logic rw, input logic [29:0] addr, input logic [31:0] wd);
        a_cpu_req = 1'b1; a_cpu_rw = rw; a_cpu_addr = addr; a_cpu_wr_data = wd;
        step();
        a_cpu_req = 1'b0;
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;

        // Reset state
        check_val("rst_req_", a_bus_req_, 1'b1);
        check_val("rst_as_", a_bus_as_, 1'b1);
        check_val("rst_rw", a_bus_rw, 1'b1);
        check_val("rst_addr", a_bus_addr, 32'd0);
        check_val("rst_wdata", a_bus_wr_data, 32'd0);
        check_val("rst_rdata", a_cpu_rd_data, 32'd0);
        check_val("rst_busy_done_err", {a_cpu_busy, a_cpu_done, a_cpu_err}, 3'b000);

        // 1: write 22 to addr 0, same-cycle grant, zero-wait slave
        a_issue(Write, 30'd0, 32'd22);
        check_val("t1_req_state", {a_bus_req_, a_cpu_busy, a_bus_as_}, 3'b011);
        step();
        check_val("t1_as_low", a_bus_as_, 1'b0);
        check_val("t1_addr_rw", {a_bus_addr, a_bus_rw}, {30'd0, 1'b0});
        check_val("t1_wdata", a_bus_wr_data, 32'd22);
        check_val("t1_no_done_yet", a_cpu_done, 1'b0);
        step();
        check_val("t1_done_err", {a_cpu_done, a_cpu_err}, 2'b10);
        check_val("t1_as_req_busy", {a_bus_as_, a_bus_req_, a_cpu_busy}, 3'b110);
        check_val("t1_mem0", a_mem[0], 32'd22);
        step();
        check_val("t1_done_pulse", a_cpu_done, 1'b0);

        // 2: read back addr 0
        a_issue(Read, 30'd0, 32'd0);
        step();
        check_val("t2_rw_read", a_bus_rw, 1'b1);
        step();
        check_val("t2_done_err", {a_cpu_done, a_cpu_err}, 2'b10);
        check_val("t2_rdata", a_cpu_rd_data, 32'd22);
        check_val("t2_req_released", a_bus_req_, 1'b1);
        step();

        // 3: another master owns the bus for 5 cycles
        a_other_owns = 1'b1;
        a_issue(Write, 30'd3, 32'h0000_A5A5);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("t3_wait_%0d", i), {a_bus_req_, a_bus_as_, a_cpu_busy}, 3'b011);
            step();
        end
        a_other_owns = 1'b0;
        step();
        check_val("t3_access", a_bus_as_, 1'b0);
        step();
        check_val("t3_done", {a_cpu_done, a_cpu_err}, 2'b10);
        check_val("t3_mem3", a_mem[3], 32'h0000_A5A5);
        step();

        // 4: slave never ready -> timeout 4 cycles into ACCESS
        a_stall = 1'b1;
        a_issue(Read, 30'd5, 32'd0);
        step();
        check_val("t4_access", a_bus_as_, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step();
            check_val($sformatf("t4_wait_%0d", i), {a_cpu_done, a_bus_as_}, 2'b00);
        end
        step();
        check_val("t4_done_err", {a_cpu_done, a_cpu_err}, 2'b11);
        check_val("t4_as_req", {a_bus_as_, a_bus_req_}, 2'b11);
        check_val("t4_rdata_kept", a_cpu_rd_data, 32'd22);
        step();

        // 4b: grant withdrawn during ACCESS -> error abort
        a_issue(Read, 30'd6, 32'd0);
        step();
        a_other_owns = 1'b1;
        step();
        check_val("t4b_done_err", {a_cpu_done, a_cpu_err}, 2'b11);
        check_val("t4b_as_req_busy", {a_bus_as_, a_bus_req_, a_cpu_busy}, 3'b110);
        a_other_owns = 1'b0;
        a_stall = 1'b0;
        step();

        // 5: hold of 2 cycles on instance B
        b_cpu_req = 1'b1; b_cpu_rw = Write; b_cpu_addr = 30'd7; b_cpu_wr_data = 32'd1;
        step();
        b_cpu_req = 1'b0;
        step();
        step();
        check_val("t5_done", {b_cpu_done, b_cpu_err, b_cpu_busy}, 3'b100);
        check_val("t5_hold_req", b_bus_req_, 1'b0);
        step();
        check_val("t5_hold_req2", {b_bus_req_, b_bus_as_}, 2'b01);
        b_cpu_req = 1'b1; b_cpu_rw = Read; b_cpu_addr = 30'd9;
        step();
        b_cpu_req = 1'b0;
        check_val("t5_direct_access", {b_bus_req_, b_bus_as_, b_cpu_busy}, 3'b001);
        check_val("t5_addr", b_bus_addr, 32'd9);
        step();
        check_val("t5_done2", b_cpu_done, 1'b1);
        check_val("t5_rdata", b_cpu_rd_data, 32'h5A5A_0009);
        step();
        check_val("t5_hold_1", b_bus_req_, 1'b0);
        step();
        check_val("t5_release", b_bus_req_, 1'b1);

        // 6: reset pulse during ACCESS
        a_stall = 1'b1;
        a_issue(Write, 30'd2, 32'd77);
        step();
        check_val("t6_access", a_bus_as_, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_val("t6_async", {a_bus_as_, a_bus_req_, a_cpu_busy}, 3'b110);
        step();
        reset = 1'b0;
        a_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("t6_no_done_%0d", i), {a_cpu_done, a_cpu_busy}, 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
